// File: rtl/l2_arbiter.sv
// Two-requester L2 line-fill arbiter (icache has priority over dcache).
// Fetches one PAGE_WORDS-long burst word by word from memory and strobes each word to the granted side.
module l2_arbiter #(
  parameter int WIDTH      = 32,
  parameter int PAGE_BYTES = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ic_start,
  input  logic [WIDTH-1:0] ic_page,
  input  logic             dc_start,
  input  logic [WIDTH-1:0] dc_page,
  output logic             l2_busy,
  output logic             ic_launch,
  output logic             dc_launch,
  output logic             ic_ready,
  output logic             dc_ready,
  output logic [15:0]      l2_data,
  output logic             mem_req,
  output logic [WIDTH-1:0] mem_addr,
  input  logic             mem_ack,
  input  logic [15:0]      mem_rdata
);

  localparam int PAGE_WORDS  = PAGE_BYTES / 2;
  localparam int OFFSET_BITS = $clog2(PAGE_BYTES);
  localparam int WORD_BITS   = (PAGE_WORDS > 1) ? $clog2(PAGE_WORDS) : 1;
  localparam logic [WORD_BITS-1:0] LAST_WORD = WORD_BITS'(PAGE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DELIVER, DRAIN} state_t;

  state_t               state;
  logic                 grant_dc;
  logic [WIDTH-1:0]     page;
  logic [WORD_BITS-1:0] word;

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      grant_dc <= 1'b0;
      page     <= '0;
      word     <= '0;
      l2_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          // icache wins a tie; a losing dcache start simply gets resampled next IDLE
          if (ic_start) begin
            grant_dc <= 1'b0;
            page     <= ic_page;
            word     <= '0;
            state    <= ISSUE;
          end else if (dc_start) begin
            grant_dc <= 1'b1;
            page     <= dc_page;
            word     <= '0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_ack) begin
            l2_data <= mem_rdata;
            state   <= DELIVER;
          end
        end
        DELIVER: begin
          if (word != LAST_WORD) begin
            word  <= word + WORD_BITS'(1);
            state <= ISSUE;
          end else begin
            state <= DRAIN;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs are pure decodes of the state registers, so none glitch on inputs.
  assign l2_busy   = (state != IDLE);
  assign ic_launch = l2_busy && !grant_dc;
  assign dc_launch = l2_busy && grant_dc;
  assign ic_ready  = (state == DELIVER) && !grant_dc;
  assign dc_ready  = (state == DELIVER) && grant_dc;
  assign mem_req   = (state == ISSUE);
  assign mem_addr  = (page << OFFSET_BITS) + WIDTH'({word, 1'b0});

endmodule

// File: tb/tb_l2_arbiter.sv
// Scoreboard bench for l2_arbiter: expected words are queued per burst and matched on each fetch and ready strobe.
module tb_l2_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ic_start = 1'b0, dc_start = 1'b0;
  logic [31:0] ic_page = '0, dc_page = '0;
  logic        l2_busy, ic_launch, dc_launch, ic_ready, dc_ready, mem_req, mem_ack;
  logic [15:0] l2_data, mem_rdata;
  logic [31:0] mem_addr;

  typedef struct {
    logic        dc;
    logic [31:0] addr;
    logic [15:0] data;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0, miscompares = 0;
  int   cyc = 0;
  int   ack_mode = 1;  // 0: ack with req, 1: ack one cycle later, 2: random delay
  logic ack_reg = 1'b0;
  int   ic_rdy_cnt = 0, dc_rdy_cnt = 0;
  logic prev_req = 1'b0, prev_ack = 1'b0, have_prev = 1'b0;
  logic [31:0] prev_addr = '0;
  int   prev_rdy_cyc = 0;

  l2_arbiter #(.WIDTH(32), .PAGE_BYTES(32)) dut (
    .clk(clk), .rst(rst),
    .ic_start(ic_start), .ic_page(ic_page),
    .dc_start(dc_start), .dc_page(dc_page),
    .l2_busy(l2_busy), .ic_launch(ic_launch), .dc_launch(dc_launch),
    .ic_ready(ic_ready), .dc_ready(dc_ready), .l2_data(l2_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // memory model: data is a fixed scramble of the byte address
  assign mem_rdata = mem_addr[15:0] ^ 16'h5A3C;
  assign mem_ack   = (ack_mode == 0) ? mem_req : ack_reg;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ack_mode == 2) ack_reg <= mem_req && !ack_reg && ($urandom_range(0, 2) == 0);
    else               ack_reg <= mem_req && !ack_reg;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_burst(input logic dc, input logic [31:0] page);
    exp_t e;
    for (int w = 0; w < 16; w++) begin
      e.dc   = dc;
      e.addr = (page << 5) + 32'(2 * w);
      e.data = e.addr[15:0] ^ 16'h5A3C;
      sbq.push_back(e);
    end
  endtask

  task automatic idle_wait(input string tag, input int budget);
    int n = 0;
    while ((sbq.size() != 0 || l2_busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk(tag, 1, 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      chk("x_on_outputs", 64'($isunknown({l2_busy, ic_launch, dc_launch, ic_ready, dc_ready,
                                            l2_data, mem_req, mem_addr})), 0);
      chk("dual_launch", 64'(ic_launch & dc_launch), 0);
      if (mem_req && prev_req && !prev_ack) chk("addr_hold", mem_addr, prev_addr);
      if (mem_req && mem_ack) begin
        if (sbq.size() == 0) chk("unexpected_fetch", 1, 0);
        else                 chk("fetch_addr", mem_addr, sbq[0].addr);
      end
      if (ic_ready || dc_ready) begin
        chk("dual_ready", 64'(ic_ready & dc_ready), 0);
        if (ic_ready) ic_rdy_cnt <= ic_rdy_cnt + 1;
        if (dc_ready) dc_rdy_cnt <= dc_rdy_cnt + 1;
        if (sbq.size() == 0) chk("unexpected_ready", 1, 0);
        else begin
          e = sbq.pop_front();
          chk("ready_owner", 64'(dc_ready), 64'(e.dc));
          chk("ready_data", 64'(l2_data), 64'(e.data));
          chk("launch_held", 64'(e.dc ? dc_launch : ic_launch), 1);
        end
        if (have_prev) begin
          chk("ready_gap_min", 64'((cyc - prev_rdy_cyc) >= 2), 1);
          if (ack_mode == 0) chk("ready_gap_comb", 64'(cyc - prev_rdy_cyc), 2);
        end
        have_prev    <= 1'b1;
        prev_rdy_cyc <= cyc;
      end else if (!l2_busy) begin
        have_prev <= 1'b0;
      end
    end else begin
      have_prev <= 1'b0;
    end
    prev_req  <= mem_req && !rst;
    prev_ack  <= mem_ack;
    prev_addr <= mem_addr;
  end

  initial begin
    int n;
    int last_ic;

    // reset values
    repeat (3) step();
    @(negedge clk);
    chk("rst_busy", 64'(l2_busy), 0);
    chk("rst_launch", 64'({ic_launch, dc_launch}), 0);
    chk("rst_ready", 64'({ic_ready, dc_ready}), 0);
    chk("rst_mem_req", 64'(mem_req), 0);
    chk("rst_l2_data", 64'(l2_data), 0);
    step();
    rst = 1'b0;
    step();

    // single icache line, ack one cycle after req
    ack_mode = 1;
    ic_rdy_cnt = 0; dc_rdy_cnt = 0;
    push_burst(1'b0, 32'h12);
    ic_page = 32'h12; ic_start = 1'b1;
    step();
    ic_start = 1'b0;
    chk("ic_launch_rise", 64'({ic_launch, dc_launch}), 64'b10);
    idle_wait("timeout_ic_only", 200);
    chk("ic_only_count", 64'(ic_rdy_cnt), 16);
    chk("ic_only_no_dc", 64'(dc_rdy_cnt), 0);

    // simultaneous starts: icache wins, dcache retries after the drain
    push_burst(1'b0, 32'h100);
    push_burst(1'b1, 32'h2AB);
    ic_page = 32'h100; dc_page = 32'h2AB;
    ic_start = 1'b1; dc_start = 1'b1;
    step();
    ic_start = 1'b0;
    chk("tie_ic_launch", 64'(ic_launch), 1);
    chk("tie_dc_launch", 64'(dc_launch), 0);
    n = 0; last_ic = cyc;
    while (!dc_launch && n < 200) begin
      if (ic_launch) last_ic = cyc;
      step();
      n++;
    end
    if (n >= 200) chk("timeout_dc_grant", 1, 0);
    dc_start = 1'b0;
    chk("dc_grant_after_drain", 64'(cyc - last_ic), 2);
    chk("dc_grant_ic_done", 64'(sbq.size()), 16);
    idle_wait("timeout_tie", 300);

    // dcache start raised mid icache burst, dropped after its first word
    push_burst(1'b0, 32'h40);
    push_burst(1'b1, 32'h41);
    ic_page = 32'h40; dc_page = 32'h41;
    ic_start = 1'b1;
    step();
    ic_start = 1'b0;
    repeat (4) step();
    dc_start = 1'b1;
    dc_rdy_cnt = 0;
    n = 0;
    while (dc_rdy_cnt == 0 && n < 300) begin
      step();
      n++;
    end
    if (n >= 300) chk("timeout_dc_first", 1, 0);
    dc_start = 1'b0;
    idle_wait("timeout_dc_held", 300);
    chk("dc_held_count", 64'(dc_rdy_cnt), 16);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("no_regrant", 64'({l2_busy, ic_launch, dc_launch}), 0);
    end

    // ack combinational with req: ready every 2 cycles
    ack_mode = 0;
    push_burst(1'b0, 32'h33);
    ic_page = 32'h33; ic_start = 1'b1;
    step();
    ic_start = 1'b0;
    idle_wait("timeout_comb", 200);

    // reset while fetching word 5 of a dcache burst
    ack_mode = 1;
    dc_rdy_cnt = 0;
    push_burst(1'b1, 32'h77);
    dc_page = 32'h77; dc_start = 1'b1;
    step();
    dc_start = 1'b0;
    n = 0;
    while (dc_rdy_cnt < 5 && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk("timeout_pre_abort", 1, 0);
    chk("abort_at_issue", 64'(mem_req), 1);
    rst = 1'b1;
    sbq.delete();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("abort_outputs", 64'({l2_busy, ic_launch, dc_launch, ic_ready, dc_ready, mem_req}), 0);
    chk("abort_data", 64'(l2_data), 0);
    chk("abort_ack_pending", 64'(mem_ack), 1);
    step();
    @(negedge clk);
    chk("abort_ack_ignored", 64'({l2_busy, dc_ready, ic_ready}), 0);
    ic_rdy_cnt = 0;
    push_burst(1'b0, 32'h5);
    step();
    ic_page = 32'h5; ic_start = 1'b1;
    step();
    ic_start = 1'b0;
    idle_wait("timeout_post_abort", 200);
    chk("post_abort_count", 64'(ic_rdy_cnt), 16);

    // address wrap at the top of the space, random ack latency
    ack_mode = 2;
    push_burst(1'b0, 32'hFFFF_FFFF);
    ic_page = 32'hFFFF_FFFF; ic_start = 1'b1;
    step();
    ic_start = 1'b0;
    chk("wrap_first_addr", 64'(mem_addr), 64'h0000_0000_FFFF_FFE0);
    idle_wait("timeout_wrap", 400);

    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got running expected done");
    $fatal(1);
  end

endmodule
